// File: rtl/burst_ram_if.sv
// Controller-to-burst_ram bus: request and addressing from the master, data handshakes back.
interface burst_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rw;
  logic                  mem_op_size;
  logic                  mem_finishes_op;
  logic [DATA_WIDTH-1:0] mem_write;
  logic                  mem_write_req;
  logic [DATA_WIDTH-1:0] mem_read;
  logic                  mem_read_valid;
  logic                  mem_last;

  modport master (
    output mem_enable, mem_addr, mem_rw, mem_op_size, mem_finishes_op, mem_write,
    input  mem_write_req, mem_read, mem_read_valid, mem_last
  );

  modport slave (
    input  mem_enable, mem_addr, mem_rw, mem_op_size, mem_finishes_op, mem_write,
    output mem_write_req, mem_read, mem_read_valid, mem_last
  );
endinterface

// File: rtl/burst_ram.sv
// Main-memory slave serving fixed cache-line bursts and open-ended streams from a synchronous RAM.
// Optional macro BURST_RAM_CRITICAL_WORD_FIRST_EN: burst reads start at the requested word.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module burst_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned LATENCY    = 2
) (
  input logic       clk,
  input logic       rst,
  burst_ram_if.slave bus
);
  localparam int unsigned OffW  = $clog2(BURST_LEN);
  localparam int unsigned WaitW = $clog2(LATENCY + 1);
  localparam logic [OffW-1:0]  LastBeat   = OffW'(BURST_LEN - 1);
  localparam logic [OffW-1:0]  PenultBeat = OffW'(BURST_LEN - 2);
  localparam logic [WaitW-1:0] WaitLoad   = WaitW'(LATENCY);

  typedef enum logic [2:0] {StIdle, StWait, StRead, StWrite, StDone} state_e;

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_next, start_ptr, aligned;
  logic [OffW-1:0]       beat_q, beat_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic                  is_write_q, is_write_d, stream_q, stream_d;
  logic [DATA_WIDTH-1:0] read_q, read_d;
  logic                  read_valid_q, read_valid_d, write_req_q, write_req_d, last_q, last_d;
  logic                  ram_we;

  // Streams walk the whole address space; bursts wrap inside their aligned line.
  always_comb begin
    ptr_next = stream_q ? ptr_q + ADDR_WIDTH'(1)
                        : {ptr_q[ADDR_WIDTH-1:OffW], ptr_q[OffW-1:0] + OffW'(1)};
    aligned  = {bus.mem_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
`ifdef BURST_RAM_CRITICAL_WORD_FIRST_EN
    start_ptr = (bus.mem_op_size || bus.mem_rw == `MEM_READ) ? bus.mem_addr : aligned;
`else
    start_ptr = bus.mem_op_size ? bus.mem_addr : aligned;
`endif
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    is_write_d   = is_write_q;
    stream_d     = stream_q;
    read_d       = '0;
    read_valid_d = 1'b0;
    write_req_d  = 1'b0;
    last_d       = 1'b0;
    ram_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_enable) begin
          is_write_d = (bus.mem_rw == `MEM_WRITE);
          stream_d   = bus.mem_op_size;
          ptr_d      = start_ptr;
          beat_d     = '0;
          wait_d     = WaitLoad;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (!bus.mem_enable) begin
          state_d = StIdle;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WaitW'(1);
        end else if (is_write_q) begin
          state_d     = StWrite;
          write_req_d = 1'b1;
        end else begin
          state_d      = StRead;
          read_d       = ram[ptr_q];
          read_valid_d = 1'b1;
          ptr_d        = ptr_next;
          beat_d       = beat_q + OffW'(1);
        end
      end
      StRead: begin
        // beat_q counts beats already issued, i.e. the index of the one issued now.
        if (!bus.mem_enable) begin
          state_d = StIdle;
        end else if (stream_q ? bus.mem_finishes_op : last_q) begin
          state_d = stream_q ? StDone : StIdle;
          last_d  = stream_q;
        end else begin
          read_d       = ram[ptr_q];
          read_valid_d = 1'b1;
          ptr_d        = ptr_next;
          beat_d       = beat_q + OffW'(1);
          last_d       = !stream_q && (beat_q == LastBeat);
        end
      end
      StWrite: begin
        // beat_q is the index of the beat currently requested.
        if (!bus.mem_enable) begin
          state_d = StIdle;
        end else begin
          ram_we = 1'b1;
          ptr_d  = ptr_next;
          beat_d = beat_q + OffW'(1);
          if (stream_q ? bus.mem_finishes_op : last_q) begin
            state_d = stream_q ? StDone : StIdle;
            last_d  = stream_q;
          end else begin
            write_req_d = 1'b1;
            last_d      = !stream_q && (beat_q == PenultBeat);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      beat_q       <= '0;
      wait_q       <= '0;
      is_write_q   <= 1'b0;
      stream_q     <= 1'b0;
      read_q       <= '0;
      read_valid_q <= 1'b0;
      write_req_q  <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      is_write_q   <= is_write_d;
      stream_q     <= stream_d;
      read_q       <= read_d;
      read_valid_q <= read_valid_d;
      write_req_q  <= write_req_d;
      last_q       <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ptr_q] <= bus.mem_write;
  end

  assign bus.mem_read       = read_q;
  assign bus.mem_read_valid = read_valid_q;
  assign bus.mem_write_req  = write_req_q;
  assign bus.mem_last       = last_q;
endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: vector table, hand-written abort/reset sequences, random traffic.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module tb_burst_ram;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int BL  = 8;
  localparam int LAT = 2;
`ifdef BURST_RAM_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  burst_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  burst_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    bit          strm;
    int          nbeats;
    int          drop_at;
    logic [31:0] wbase;
    bit          rnd;
    bit          chk_first;
    logic [31:0] exp_first;
    int          exp_beats;
    int          exp_lasts;
  } vec_t;

  logic [31:0] model [65536];
  bit          known [65536];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk(name, {bus.mem_read, bus.mem_read_valid, bus.mem_write_req, bus.mem_last}, 64'd0);
  endtask

  // Address touched by beat i, straight from the addressing rules.
  function automatic logic [15:0] exp_addr(input vec_t v, input int i);
    int base, off0;
    if (v.strm) return 16'((int'(v.addr) + i) % 65536);
    base = int'(v.addr) - int'(v.addr) % BL;
    off0 = (Cwf && !v.wr) ? int'(v.addr) % BL : 0;
    return 16'(base + (off0 + i) % BL);
  endfunction

  task automatic run_txn(input vec_t v, output int beats, output int lasts,
                         output logic [31:0] first);
    int          n;
    logic [15:0] a;
    logic [31:0] wd;
    n     = v.strm ? v.nbeats : BL;
    beats = 0;
    lasts = 0;
    first = '0;
    bus.mem_enable      = 1'b1;
    bus.mem_addr        = v.addr;
    bus.mem_rw          = v.wr ? `MEM_WRITE : `MEM_READ;
    bus.mem_op_size     = v.strm;
    bus.mem_finishes_op = 1'b0;
    bus.mem_write       = '0;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      chk_idle("wait_quiet");
      bus.mem_finishes_op = v.rnd ? 1'($urandom) : 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      tick();
      a = exp_addr(v, i);
      if (v.wr ? bus.mem_write_req : bus.mem_read_valid) beats++;
      if (bus.mem_last) lasts++;
      chk("beat_strobe", {bus.mem_read_valid, bus.mem_write_req}, v.wr ? 2'b01 : 2'b10);
      chk("beat_last", bus.mem_last, !v.strm && i == BL - 1);
      if (!v.wr) begin
        if (i == 0) first = bus.mem_read;
        if (known[a]) chk("read_data", bus.mem_read, model[a]);
      end
      if (i == v.drop_at) begin
        bus.mem_enable = 1'b0;
        tick();
        chk_idle("abort_quiet");
        return;
      end
      if (v.wr) begin
        wd            = v.rnd ? $urandom : v.wbase + 32'(i);
        bus.mem_write = wd;
        model[a]      = wd;
        known[a]      = 1'b1;
      end
      bus.mem_finishes_op = v.strm ? (i == n - 1) : (v.rnd ? 1'($urandom) : 1'b0);
    end
    tick();
    bus.mem_finishes_op = 1'b0;
    if (v.strm) begin
      if (bus.mem_last) lasts++;
      chk("done_cycle", {bus.mem_last, bus.mem_read_valid, bus.mem_write_req}, 3'b100);
      tick();
    end
    bus.mem_enable = 1'b0;
    chk_idle("post_idle");
  endtask

  task automatic apply(input vec_t v, input string name);
    int          beats, lasts;
    logic [31:0] first;
    run_txn(v, beats, lasts, first);
    chk({name, "_beats"}, beats, v.exp_beats);
    chk({name, "_lasts"}, lasts, v.exp_lasts);
    if (v.chk_first) chk({name, "_first"}, first, v.exp_first);
  endtask

  vec_t vecs [11];

  initial begin
    vec_t        v;
    int          n;
    logic [15:0] a;

    // addr, wr, strm, nbeats, drop_at, wbase, rnd, chk_first, exp_first, exp_beats, exp_lasts
    vecs[0]  = '{16'h0010, 1, 0, 0, -1, 32'hA0,  0, 0, 32'h0,   8, 1};
    vecs[1]  = '{16'h0013, 0, 0, 0, -1, 32'h0,   0, 1, Cwf ? 32'hA3 : 32'hA0, 8, 1};
    vecs[2]  = '{16'h0020, 1, 0, 0, -1, 32'h100, 0, 0, 32'h0,   8, 1};
    vecs[3]  = '{16'h0025, 0, 0, 0, -1, 32'h0,   0, 1, Cwf ? 32'h105 : 32'h100, 8, 1};
    vecs[4]  = '{16'hFFFE, 1, 1, 4, -1, 32'h1,   0, 0, 32'h0,   4, 1};
    vecs[5]  = '{16'hFFFE, 0, 1, 4, -1, 32'h0,   0, 1, 32'h1,   4, 1};
    vecs[6]  = '{16'h0040, 1, 0, 0, -1, 32'h400, 0, 0, 32'h0,   8, 1};
    vecs[7]  = '{16'h0040, 0, 1, 3, -1, 32'h0,   0, 1, 32'h400, 3, 1};
    vecs[8]  = '{16'h0030, 1, 0, 0, -1, 32'h300, 0, 0, 32'h0,   8, 1};
    vecs[9]  = '{16'h0030, 1, 0, 0,  3, 32'h900, 0, 0, 32'h0,   4, 0};
    vecs[10] = '{16'h0036, 0, 0, 0, -1, 32'h0,   0, 1, Cwf ? 32'h306 : 32'h900, 8, 1};

    bus.mem_enable      = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_rw          = `MEM_READ;
    bus.mem_op_size     = 1'b0;
    bus.mem_finishes_op = 1'b0;
    bus.mem_write       = '0;
    for (int i = 0; i < 65536; i++) known[i] = 1'b0;

    tick();
    tick();
    chk_idle("reset_state");
    rst = 1'b0;
    tick();
    chk_idle("after_reset");

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Abort a burst read at beat 5 with an asynchronous reset pulse.
    v = vecs[1];
    v.addr = 16'h0010;
    bus.mem_enable  = 1'b1;
    bus.mem_addr    = v.addr;
    bus.mem_rw      = `MEM_READ;
    bus.mem_op_size = 1'b0;
    for (int k = 0; k <= LAT + 6; k++) tick();
    a = exp_addr(v, 5);
    chk("pre_reset_beat", {bus.mem_read_valid, bus.mem_read}, {1'b1, model[a]});
    #2 rst = 1'b1;
    #1 chk_idle("async_reset");
    bus.mem_enable = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk_idle("post_reset_idle");
    v.chk_first = 1'b1;
    v.exp_first = 32'hA0;
    apply(v, "reread");

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      v.addr    = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                              : 16'($urandom_range(0, 127));
      v.wr      = 1'($urandom);
      v.strm    = 1'($urandom);
      v.nbeats  = $urandom_range(1, 6);
      n         = v.strm ? v.nbeats : BL;
      v.drop_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, v.strm ? n - 1 : BL - 2) : -1;
      v.wbase   = '0;
      v.rnd     = 1'b1;
      v.chk_first = 1'b0;
      v.exp_first = '0;
      v.exp_beats = (v.drop_at >= 0) ? v.drop_at + 1 : n;
      v.exp_lasts = (v.drop_at >= 0) ? 0 : 1;
      apply(v, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
